// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional parity, stop bit.
// One bit is consumed per bit_en strobe; outputs are registered with single-cycle status pulses.
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    localparam int       CW   = (DATA_W < 2) ? 1 : $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic     PEN  = (PARITY_EN != 0);
    localparam logic     ODD  = (PARITY_ODD != 0);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_next;
    logic              par_bit;

    // LSB arrives first, so new bits enter at the top and walk down.
    always_comb begin
        sh_next = shreg >> 1;
        sh_next[DATA_W-1] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_en) begin
                case (state)
                    S_IDLE: begin
                        if (!d) begin
                            state <= S_DATA;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shreg <= sh_next;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= PEN ? S_PAR : S_STOP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_PAR: begin
                        par_bit <= d;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (d) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            parity_err <= PEN & (^shreg ^ par_bit ^ ODD);
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Upstream serial-frame deserializer for the single-bit registered data path.
- Consumes one serial bit per qualified clock: start bit, DATA_W data bits LSB first, optional parity bit, stop bit.
- Presents a parallel word with a one-cycle valid pulse and error flags to downstream logic.
- One bit per bit_en strobe; no oversampling. Bit timing comes from the upstream bit-rate generator.

Parameters:
DATA_W, 8, number of data bits per frame (range 1..16)
PARITY_EN, 1, 1 = parity bit present after data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  reset, asynchronous, active-low
d  input  1  serial data in; idles high; start bit = 0, stop bit = 1
bit_en  input  1  bit strobe; d is sampled only on a clk rising edge with bit_en=1
data_out  output  DATA_W  last received word; holds its value between frames
data_valid  output  1  one-cycle pulse when a frame completes with a good stop bit
parity_err  output  1  one-cycle pulse alongside data_valid when parity mismatches
frame_err  output  1  one-cycle pulse when the stop bit samples 0
busy  output  1  high from start-bit acceptance until the frame completes

Behaviour:
- Reset: rst_n low immediately forces state=IDLE, bit counter=0, shift register=0, and all outputs to 0 (data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0).
- Reset mid-frame aborts the partial frame. No pulse is generated and no partial data reaches data_out.
- All outputs are registered. data_valid, parity_err and frame_err default to 0 every cycle and are never high for more than one clk.
- When bit_en=0: state, counter and shift register hold, and no sampling occurs. Pulses still deassert on the next clk.
- FSM (all transitions happen only on edges with bit_en=1):
  - IDLE: d=0 -> DATA, counter=0, busy=1. d=1 -> stay in IDLE.
  - DATA: shift d into the MSB end of the register (LSB-first reception) and increment the counter. After the DATA_W-th bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: capture d as the received parity bit -> STOP.
  - STOP, d=1: load data_out, pulse data_valid, set parity_err = (XOR of data bits XOR received parity XOR PARITY_ODD) when PARITY_EN, else 0 -> IDLE, busy=0.
  - STOP, d=0: pulse frame_err, data_valid=0, parity_err=0, data_out unchanged -> IDLE, busy=0.
- A parity error still delivers the data: data_valid=1 and parity_err=1 in the same cycle.
- Latency with bit_en held high and start bit sampled at edge 0:
  - data bits at edges 1..DATA_W; parity at edge DATA_W+1; stop at edge DATA_W+2 (DATA_W+1 without parity).
  - Pulses are visible in the cycle following the stop-sampling edge.
  - Default parameters: stop sampled at edge 10, data_valid high between edges 10 and 11.
- Back-to-back frames: a start bit is accepted on the first bit_en edge after returning to IDLE, with no gap required.
- A stop bit of 0 does not re-trigger: the FSM enters IDLE and needs a fresh sampled 0 to start a new frame. A d=0 stop followed by d=0 is therefore treated as the start of a new frame.
- No glitch filtering of start bits. A single sampled 0 in IDLE starts a frame.

Test Plan:
- Defaults, bit_en=1. Send 0xA5: start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> data_out=0xA5, data_valid=1 for exactly one cycle after the edge-10 sample, parity_err=0, frame_err=0, busy high across edges 0..10.
- Same frame with parity bit 1 -> data_out=0xA5, data_valid=1 and parity_err=1 in the same cycle.
- After a good 0xA5, send a frame 0x3C with stop bit 0 -> frame_err=1 for one cycle, data_valid=0, data_out stays 0xA5, FSM back in IDLE.
- bit_en toggled 1,0,1,0…, frame 0x3C (parity 0) -> data_out=0x3C with data_valid after the 11th qualified edge. State holds on every bit_en=0 cycle.
- rst_n pulsed low after 4 data bits of 0xFF -> busy=0 and all outputs 0 asynchronously. A following 0x3C frame is received correctly with no error pulses.
- Two frames 0x01 then 0x80 back-to-back, stop immediately followed by start -> two data_valid pulses 11 cycles apart, data_out=0x01 then 0x80, no errors.
